// File: rtl/sdrc_bank_req_q.sv
// Per-controller request queue between the request generator and the bank FSMs.
// Holds burst chunks in FIFO order and tracks the open row of each bank for page-hit hints.
module sdrc_bank_req_q #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int LEN_W = 12
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       r2b_req,
    input  logic [ID_W-1:0]            r2b_req_id,
    input  logic                       r2b_start,
    input  logic                       r2b_last,
    input  logic                       r2b_wrap,
    input  logic [1:0]                 r2b_ba,
    input  logic [12:0]                r2b_raddr,
    input  logic [12:0]                r2b_caddr,
    input  logic [LEN_W-1:0]           r2b_len,
    input  logic                       r2b_write,
    output logic                       b2r_ack,
    output logic                       b2r_arb_ok,

    input  logic                       q_pop,
    input  logic                       close_all,
    output logic                       q_valid,
    output logic [ID_W-1:0]            q_id,
    output logic                       q_start,
    output logic                       q_last,
    output logic                       q_wrap,
    output logic [1:0]                 q_ba,
    output logic [12:0]                q_raddr,
    output logic [12:0]                q_caddr,
    output logic [LEN_W-1:0]           q_len,
    output logic                       q_write,
    output logic                       q_page_hit,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ARB_CNT  = CW'(DEPTH - 2);
    localparam int NBANK = 4;

    // Entry storage is intentionally unreset; validity comes from r_count alone.
    logic [ID_W-1:0]   r_id    [DEPTH];
    logic              r_start [DEPTH];
    logic              r_last  [DEPTH];
    logic              r_wrap  [DEPTH];
    logic [1:0]        r_ba    [DEPTH];
    logic [12:0]       r_raddr [DEPTH];
    logic [12:0]       r_caddr [DEPTH];
    logic [LEN_W-1:0]  r_len   [DEPTH];
    logic              r_write [DEPTH];

    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic [NBANK-1:0]  r_row_valid;
    logic [12:0]       r_row [NBANK];

    logic              w_push;
    logic              w_pop;
    logic              w_row_match;

    // Accept/pop decisions use the registered count only; a pop at full does not
    // admit a push in the same cycle.
    assign b2r_ack    = reset_n & r2b_req & (r_count < FULL_CNT);
    assign b2r_arb_ok = reset_n & (r_count <= ARB_CNT);
    assign q_valid    = reset_n & (r_count != '0);

    assign w_push = b2r_ack;
    assign w_pop  = q_pop & q_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_id[r_wptr]    <= r2b_req_id;
            r_start[r_wptr] <= r2b_start;
            r_last[r_wptr]  <= r2b_last;
            r_wrap[r_wptr]  <= r2b_wrap;
            r_ba[r_wptr]    <= r2b_ba;
            r_raddr[r_wptr] <= r2b_raddr;
            r_caddr[r_wptr] <= r2b_caddr;
            r_len[r_wptr]   <= r2b_len;
            r_write[r_wptr] <= r2b_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign q_id    = r_id[r_rptr];
    assign q_start = r_start[r_rptr];
    assign q_last  = r_last[r_rptr];
    assign q_wrap  = r_wrap[r_rptr];
    assign q_ba    = r_ba[r_rptr];
    assign q_raddr = r_raddr[r_rptr];
    assign q_caddr = r_caddr[r_rptr];
    assign q_len   = r_len[r_rptr];
    assign q_write = r_write[r_rptr];
    assign q_count = r_count;

    // Open-row table: a popped entry opens its row; close_all overrides any pop.
    genvar b;
    generate
        for (b = 0; b < NBANK; b++) begin : g_bank
            always_ff @(posedge clk) begin
                if (!reset_n || close_all)
                    r_row_valid[b] <= 1'b0;
                else if (w_pop && q_ba == 2'(b))
                    r_row_valid[b] <= 1'b1;
            end

            always_ff @(posedge clk) begin
                if (reset_n && w_pop && q_ba == 2'(b))
                    r_row[b] <= q_raddr;
            end
        end
    endgenerate

    assign w_row_match = r_row_valid[q_ba] & (r_row[q_ba] == q_raddr);
    assign q_page_hit  = q_valid & w_row_match;

endmodule

// File: tb/tb_sdrc_bank_req_q.sv
// Scoreboard bench for sdrc_bank_req_q: accepted chunks are queued as expectations,
// a negedge monitor checks every popped head entry against them in order.
module tb_sdrc_bank_req_q;

    typedef struct packed {
        logic [3:0]  id;
        logic        start;
        logic        last;
        logic        wrap;
        logic [1:0]  ba;
        logic [12:0] raddr;
        logic [12:0] caddr;
        logic [11:0] len;
        logic        write;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        r2b_req;
    logic [3:0]  r2b_req_id;
    logic        r2b_start, r2b_last, r2b_wrap, r2b_write;
    logic [1:0]  r2b_ba;
    logic [12:0] r2b_raddr, r2b_caddr;
    logic [11:0] r2b_len;
    logic        b2r_ack, b2r_arb_ok;
    logic        q_pop, close_all, q_valid;
    logic [3:0]  q_id;
    logic        q_start, q_last, q_wrap, q_write, q_page_hit;
    logic [1:0]  q_ba;
    logic [12:0] q_raddr, q_caddr;
    logic [11:0] q_len;
    logic [2:0]  q_count;

    sdrc_bank_req_q #(.DEPTH(4), .ID_W(4), .LEN_W(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_start(r2b_start),
        .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_ba(r2b_ba),
        .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
        .r2b_write(r2b_write), .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok),
        .q_pop(q_pop), .close_all(close_all), .q_valid(q_valid),
        .q_id(q_id), .q_start(q_start), .q_last(q_last), .q_wrap(q_wrap),
        .q_ba(q_ba), .q_raddr(q_raddr), .q_caddr(q_caddr), .q_len(q_len),
        .q_write(q_write), .q_page_hit(q_page_hit), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    ent_t sb[$];
    ent_t cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any head that is actually popped must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && q_pop && q_valid) begin
            ent_t got, exp;
            got = '{q_id, q_start, q_last, q_wrap, q_ba, q_raddr, q_caddr, q_len, q_write};
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL pop_unexpected: got id %0h expected no entry", q_id);
            end else begin
                exp = sb.pop_front();
                chk($sformatf("pop_entry_id%0h", exp.id), 64'(got), 64'(exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] id, input logic st, input logic la,
                           input logic wr, input logic [1:0] ba, input logic [12:0] ra,
                           input logic [12:0] ca, input logic [11:0] ln, input logic we);
        cur = '{id, st, la, wr, ba, ra, ca, ln, we};
        r2b_req = 1'b1; r2b_req_id = id; r2b_start = st; r2b_last = la; r2b_wrap = wr;
        r2b_ba = ba; r2b_raddr = ra; r2b_caddr = ca; r2b_len = ln; r2b_write = we;
    endtask

    task automatic expect_ack(input logic e);
        #1;
        chk("b2r_ack", 64'(b2r_ack), 64'(e));
        if (e) sb.push_back(cur);
    endtask

    task automatic pop_n(input int n);
        q_pop = 1'b1;
        repeat (n) step();
        q_pop = 1'b0;
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        reset_n = 1'b0; r2b_req = 1'b0; q_pop = 1'b0; close_all = 1'b0;
        r2b_req_id = '0; r2b_start = 0; r2b_last = 0; r2b_wrap = 0; r2b_write = 0;
        r2b_ba = '0; r2b_raddr = '0; r2b_caddr = '0; r2b_len = '0;
        step(); step();
        // Outputs held quiet during reset even with a live request.
        set_req(4'hF, 1, 1, 0, 2'd0, 13'h1, 13'h1, 12'd1, 0);
        #1;
        chk("rst_ack", 64'(b2r_ack), 0);
        chk("rst_arb_ok", 64'(b2r_arb_ok), 0);
        chk("rst_q_valid", 64'(q_valid), 0);
        chk("rst_page_hit", 64'(q_page_hit), 0);
        step();
        r2b_req = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_count", 64'(q_count), 0);
        chk("post_rst_arb_ok", 64'(b2r_arb_ok), 1);

        // Single chunk
        step();
        set_req(4'h0, 1, 1, 0, 2'd2, 13'h015, 13'h0F0, 12'd8, 1);
        expect_ack(1);
        step();
        r2b_req = 1'b0;
        #1;
        chk("single_q_valid", 64'(q_valid), 1);
        chk("single_count", 64'(q_count), 1);
        chk("single_page_hit", 64'(q_page_hit), 0);
        pop_n(1);
        #1;
        chk("single_drained", 64'(q_count), 0);

        // Fill to full, hold off the 5th chunk, then release it with one pop
        for (int i = 1; i <= 4; i++) begin
            step();
            set_req(4'(i), 1, 1, i[0], 2'd0, 13'(i), 13'(16 * i), 12'(i), i[1]);
            #1;
            chk($sformatf("fill_arb_ok_%0d", i), 64'(b2r_arb_ok), (i <= 3) ? 64'd1 : 64'd0);
            expect_ack(1);
        end
        step();
        set_req(4'h5, 1, 1, 1, 2'd0, 13'h5, 13'h50, 12'd5, 1);
        #1;
        chk("full_count", 64'(q_count), 4);
        chk("full_arb_ok", 64'(b2r_arb_ok), 0);
        expect_ack(0);
        step();
        q_pop = 1'b1;
        expect_ack(0);
        step();
        q_pop = 1'b0;
        expect_ack(1);
        step();
        r2b_req = 1'b0;
        #1;
        chk("refill_count", 64'(q_count), 4);
        pop_n(4);
        #1;
        chk("fill_drained", 64'(q_count), 0);

        // Split request, then push+pop at count 2
        step();
        set_req(4'h6, 1, 0, 1, 2'd3, 13'h020, 13'h0FC, 12'd4, 0);
        #1;
        chk("split_arb_ok", 64'(b2r_arb_ok), 1);
        expect_ack(1);
        step();
        set_req(4'h7, 0, 1, 1, 2'd3, 13'h020, 13'h000, 12'd4, 0);
        expect_ack(1);
        step();
        r2b_req = 1'b0;
        #1;
        chk("split_count", 64'(q_count), 2);
        chk("split_head_start", 64'({q_start, q_last}), 64'(2'b10));
        set_req(4'h8, 1, 1, 0, 2'd3, 13'h021, 13'h010, 12'd2, 1);
        q_pop = 1'b1;
        expect_ack(1);
        step();
        r2b_req = 1'b0; q_pop = 1'b0;
        #1;
        chk("pushpop_count", 64'(q_count), 2);
        chk("pushpop_head_id", 64'(q_id), 7);
        pop_n(2);

        // Page hit tracking on bank 1
        step();
        set_req(4'h9, 1, 1, 0, 2'd1, 13'h100, 13'h0, 12'd1, 0);
        expect_ack(1);
        step();
        set_req(4'hA, 1, 1, 0, 2'd1, 13'h100, 13'h8, 12'd1, 0);
        expect_ack(1);
        step();
        set_req(4'hB, 1, 1, 0, 2'd1, 13'h101, 13'h10, 12'd1, 1);
        expect_ack(1);
        step();
        set_req(4'hC, 1, 1, 0, 2'd1, 13'h101, 13'h18, 12'd1, 1);
        expect_ack(1);
        step();
        r2b_req = 1'b0;
        #1;
        chk("hit_cold", 64'(q_page_hit), 0);
        pop_n(1);
        #1;
        chk("hit_same_row", 64'(q_page_hit), 1);
        pop_n(1);
        #1;
        chk("hit_other_row", 64'(q_page_hit), 0);
        pop_n(1);
        #1;
        chk("hit_reopen", 64'(q_page_hit), 1);
        // close_all with a pop: the pop's row must not survive
        set_req(4'hD, 1, 1, 0, 2'd1, 13'h101, 13'h20, 12'd1, 0);
        q_pop = 1'b1; close_all = 1'b1;
        expect_ack(1);
        step();
        r2b_req = 1'b0; q_pop = 1'b0; close_all = 1'b0;
        #1;
        chk("close_valid", 64'(q_valid), 1);
        chk("close_hit_bank1", 64'(q_page_hit), 0);
        set_req(4'hE, 1, 1, 0, 2'd0, 13'h005, 13'h28, 12'd1, 0);
        expect_ack(1);
        step();
        r2b_req = 1'b0;
        pop_n(1);
        #1;
        chk("close_hit_bank0", 64'(q_page_hit), 0);
        pop_n(1);

        // Reset mid-operation discards queued entries
        for (int i = 0; i < 3; i++) begin
            step();
            set_req(4'(i), 1, 1, 0, 2'(i), 13'(i), 13'(i), 12'(i), 0);
            expect_ack(1);
        end
        step();
        r2b_req = 1'b0;
        #1;
        chk("pre_rst_count", 64'(q_count), 3);
        reset_n = 1'b0;
        sb.delete();
        step();
        reset_n = 1'b1;
        #1;
        chk("mid_rst_count", 64'(q_count), 0);
        chk("mid_rst_valid", 64'(q_valid), 0);
        chk("mid_rst_hit", 64'(q_page_hit), 0);
        chk("mid_rst_arb_ok", 64'(b2r_arb_ok), 1);

        // Pop while empty is ignored
        pop_n(2);
        #1;
        chk("empty_pop_count", 64'(q_count), 0);
        chk("sb_empty", 64'(sb.size()), 0);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
